// File: rtl/hp_add_arbiter.sv
// hp_add_arbiter: round-robin front end that time-shares one external
// combinational half-precision adder among NREQ valid/ready requesters.
// Flow per operation: IDLE (grant + latch operands) -> ISSUE (adder settles,
// result captured) -> RESP (result held until the owner accepts it).
module hp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [15:0]          resp_sum,
  output logic [1:0]           resp_exc,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [15:0]          add_sum,
  input  logic [1:0]           add_exc,
  output logic                 busy,
  output logic [15:0]          done_cnt,
  output logic [7:0]           exc_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [IDW-1:0]  winner;
  logic            found;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] id_onehot;
  logic            take;
  logic            accept;

  // Unpacked views of the flat operand buses, one entry per requester.
  logic [15:0] a_arr [NREQ];
  logic [15:0] b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[16*gi +: 16];
    assign b_arr[gi] = req_b[16*gi +: 16];
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << winner;
  assign id_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << resp_id;

  // Round-robin search: first valid requester after the last winner.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    resp_valid = '0;
    busy       = 1'b0;
    take       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          // found implies req_valid[winner], so presenting ready completes
          // the handshake this cycle.
          req_ready  = win_onehot;
          take       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        busy       = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = id_onehot;
        if (resp_ready[resp_id]) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Grant bookkeeping and operand latch; operands persist to avoid toggling the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= IDW'(NREQ - 1);
      resp_id    <= '0;
      add_a      <= '0;
      add_b      <= '0;
    end else if (take) begin
      rr_ptr_reg <= winner;
      resp_id    <= winner;
      add_a      <= a_arr[winner];
      add_b      <= b_arr[winner];
    end
  end

  // Capture the settled adder output at the end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_sum <= '0;
      resp_exc <= '0;
    end else if (state_reg == ISSUE) begin
      resp_sum <= add_sum;
      resp_exc <= add_exc;
    end
  end

  // Completion counters: done wraps naturally, exception count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
      exc_cnt  <= '0;
    end else if (accept) begin
      done_cnt <= done_cnt + 16'd1;
      if ((resp_exc != 2'b00) && (exc_cnt != 8'hFF)) begin
        exc_cnt <= exc_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/hp_add_arbiter.md
Name: hp_add_arbiter

Overview:
- Shares one combinational half-precision adder (16-bit in/out, 2-bit exception: 00 normal/zero, 01 infinity, 11 NaN) among NREQ requesters.
- Per-requester valid/ready request and response channels.
- Round-robin grant; operands are latched and driven to the adder for one cycle, and the sum/exception is registered.
- The result is returned to the granting requester and held until it is accepted.
- Sits between the FP client logic and the shared hp_adder instance; the adder is external and connects through the add_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the grant ID, equal to clog2(NREQ); minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_a  input  16*NREQ  operand A; requester i uses bits [16i+15:16i].
- req_b  input  16*NREQ  operand B; same slicing as req_a.
- req_ready  output  NREQ  one-hot accept for the winning requester.
- resp_valid  output  NREQ  one-hot; result available for the owning requester.
- resp_ready  input  NREQ  per-requester result accept.
- resp_sum  output  16  registered adder sum (shared bus).
- resp_exc  output  2  registered adder exception (shared bus).
- resp_id  output  IDW  index of the current owner.
- add_a  output  16  to the shared adder, input A.
- add_b  output  16  to the shared adder, input B.
- add_sum  input  16  from the shared adder.
- add_exc  input  2  from the shared adder.
- busy  output  1  high in ISSUE or RESP.
- done_cnt  output  16  completed operations; wraps 0xFFFF to 0.
- exc_cnt  output  8  completions with resp_exc != 00; saturates at 0xFF.

Behaviour:
- Reset, asynchronous while rst_n is low:
  - state=IDLE, rr_ptr=NREQ-1.
  - add_a, add_b, resp_sum, resp_exc, resp_id, done_cnt, exc_cnt all 0.
  - resp_valid=0, busy=0.
  - Any in-flight operation is discarded; no response is emitted after reset.
- IDLE:
  - Winner = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready[winner]=1 combinationally, all other bits 0. req_ready is 0 in every other state.
  - On handshake (req_valid & req_ready): add_a<=req_a[winner], add_b<=req_b[winner], resp_id<=winner, rr_ptr<=winner, go to ISSUE.
  - If no request is pending, stay in IDLE and keep rr_ptr unchanged.
- ISSUE, exactly one cycle:
  - add_a/add_b are stable, so the adder output is settled by the clock edge.
  - Capture resp_sum<=add_sum and resp_exc<=add_exc; go to RESP.
- RESP:
  - resp_valid[resp_id]=1.
  - Wait for resp_ready[resp_id]. resp_ready bits of other requesters are ignored.
  - On acceptance: done_cnt+=1; exc_cnt+=1 if resp_exc!=00 and exc_cnt!=0xFF; go to IDLE.
  - resp_sum, resp_exc and resp_id are stable for the whole RESP state.
- Signals held outside their active state:
  - add_a/add_b hold the last operands in all states, to avoid needless toggling.
  - resp_sum/resp_exc hold their last value after acceptance.
- Timing:
  - Latency from handshake cycle T: ISSUE at T+1, resp_valid high from T+2.
  - Minimum period per operation is 3 cycles with resp_ready tied high.
- Fairness: continuously requesting clients are served in strict rotation. A requester waits at most NREQ-1 operations.
- Requests arriving while busy are not accepted. Requesters must hold req_valid and operands stable until req_ready.
- A requester may hold req_valid while its own response is pending; it re-arbitrates in the next IDLE.
- Arithmetic and exception rules (NaN propagation, infinity, zero bypass) are owned entirely by the adder. This block never modifies sum or exception bits.

Test Plan:
1. Single op on requester 0, real hp_adder attached: A=0x3C00 (1.0), B=0x3C00 -> req_ready[0] in cycle T, resp_valid=4'b0001 from T+2, resp_sum=0x4000, resp_exc=00, done_cnt=1.
2. All four requesters continuously valid after reset, resp_ready tied 1 -> grant order 0,1,2,3,0,1; one response every 3 cycles; each resp_id matches its own operands (e.g. req2 0x4000+0x3C00 -> 0x4200).
3. Exceptions:
   - 0x7C00 + 0xFC00 -> resp_sum=0x7C01, resp_exc=11.
   - 0x7E00 + 0x3C00 -> resp_sum=0x7E00, resp_exc=11.
   - 0x7C00 + 0x3C00 -> resp_exc=01.
   - After all three, exc_cnt=3.
4. Backpressure: resp_ready[1]=0 for 10 cycles -> resp_valid[1] and resp_sum stay stable; req_ready stays 0 for others; after resp_ready[1]=1 for one cycle, IDLE, then the next grant follows rotation.
5. Reset mid-operation: assert rst_n=0 during ISSUE, then during RESP -> all outputs 0 immediately, no response after release, first grant goes to requester 0.
6. Counters: preload by running 0x10000 ops (or force done_cnt=0xFFFF) -> wraps to 0. With exc_cnt forced to 0xFF, a further NaN op leaves exc_cnt=0xFF.
